// File: rtl/neander_io_port_pkg.sv
// Shared constants for the NEANDER-X I/O port: status bit positions and
// the CPU-visible IN port addresses.
package neander_io_pkg;

    localparam int ST_RX_AVAIL    = 0;
    localparam int ST_TX_FULL     = 1;
    localparam int ST_TX_EMPTY    = 2;
    localparam int ST_TX_DROPPED  = 3;
    localparam int ST_RX_UNDERRUN = 4;

    localparam logic [7:0] IO_PORT_DATA   = 8'h00;
    localparam logic [7:0] IO_PORT_STATUS = 8'h01;

endpackage

// File: rtl/neander_io_port_fifo.sv
// Small synchronous FIFO with a combinational head read. The caller must only
// push when not full (or while popping) and only pop when not empty.
module io_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    // Storage carries no reset; stale entries are unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == (AW+1)'(DEPTH));
    assign empty = (r_count == '0);

endmodule

// File: rtl/neander_io_port.sv
// NEANDER-X peripheral I/O responder: buffers CPU OUT bytes towards an external
// sink and external bytes towards CPU IN ports, with sticky error flags.
module neander_io_port
    import neander_io_pkg::*;
#(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] io_out,
    input  logic       io_write,
    input  logic       io_read,
    output logic [7:0] io_in,
    output logic [7:0] io_status,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready
);

    localparam int TXCW = $clog2(TX_DEPTH) + 1;
    localparam int RXCW = $clog2(RX_DEPTH) + 1;

    logic [7:0]      w_tx_head;
    logic [TXCW-1:0] w_tx_count;
    logic            w_tx_full;
    logic            w_tx_empty;
    logic            w_tx_push;
    logic            w_tx_pop;
    logic            w_tx_drop;

    logic [7:0]      w_rx_head;
    logic [RXCW-1:0] w_rx_count;
    logic            w_rx_full;
    logic            w_rx_empty;
    logic            w_rx_push;
    logic            w_rx_pop;
    logic            w_rx_underrun;

    logic            r_tx_dropped;
    logic            r_rx_underrun;

    // A full TX FIFO still accepts a write when the sink drains the head on the same edge.
    assign w_tx_pop      = !w_tx_empty && tx_ready;
    assign w_tx_push     = io_write && (!w_tx_full || w_tx_pop);
    assign w_tx_drop     = io_write && w_tx_full && !w_tx_pop;

    assign w_rx_push     = rx_valid && !w_rx_full;
    assign w_rx_pop      = io_read && !w_rx_empty;
    assign w_rx_underrun = io_read && w_rx_empty;

    io_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_tx_push),
        .pop   (w_tx_pop),
        .din   (io_out),
        .dout  (w_tx_head),
        .count (w_tx_count),
        .full  (w_tx_full),
        .empty (w_tx_empty)
    );

    io_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_rx_push),
        .pop   (w_rx_pop),
        .din   (rx_data),
        .dout  (w_rx_head),
        .count (w_rx_count),
        .full  (w_rx_full),
        .empty (w_rx_empty)
    );

    // A successful data read acknowledges both error flags; a new error on the same edge wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_dropped  <= 1'b0;
            r_rx_underrun <= 1'b0;
        end else begin
            if (w_tx_drop) begin
                r_tx_dropped <= 1'b1;
            end else if (w_rx_pop) begin
                r_tx_dropped <= 1'b0;
            end
            if (w_rx_underrun) begin
                r_rx_underrun <= 1'b1;
            end else if (w_rx_pop) begin
                r_rx_underrun <= 1'b0;
            end
        end
    end

    always_comb begin
        io_status                 = 8'h00;
        io_status[ST_RX_AVAIL]    = (w_rx_count != '0);
        io_status[ST_TX_FULL]     = (w_tx_count == TXCW'(TX_DEPTH));
        io_status[ST_TX_EMPTY]    = (w_tx_count == '0);
        io_status[ST_TX_DROPPED]  = r_tx_dropped;
        io_status[ST_RX_UNDERRUN] = r_rx_underrun;
    end

    assign tx_valid = !w_tx_empty;
    assign tx_data  = w_tx_empty ? 8'h00 : w_tx_head;
    assign io_in    = w_rx_empty ? 8'h00 : w_rx_head;
    assign rx_ready = !w_rx_full;

endmodule

// File: tb/tb_neander_io_port.sv
// Scoreboard bench for neander_io_port: a queue model of both FIFOs and the
// sticky flags predicts every output each cycle.
module tb_neander_io_port;

    localparam int TXD = 4;
    localparam int RXD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] io_out;
    logic       io_write;
    logic       io_read;
    logic [7:0] io_in;
    logic [7:0] io_status;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] tx_q [$];
    logic [7:0] rx_q [$];
    bit         m_drop;
    bit         m_und;

    neander_io_port #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk       (clk),
        .reset     (reset),
        .io_out    (io_out),
        .io_write  (io_write),
        .io_read   (io_read),
        .io_in     (io_in),
        .io_status (io_status),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        logic [7:0] exp_st;
        logic [7:0] exp_tx;
        logic [7:0] exp_rx;
        exp_st = {3'b000, m_und, m_drop, tx_q.size() == 0, tx_q.size() == TXD, rx_q.size() != 0};
        exp_tx = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
        exp_rx = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
        check_eq("io_status", io_status, exp_st);
        check_eq("tx_valid", {7'b0, tx_valid}, {7'b0, tx_q.size() != 0});
        check_eq("tx_data", tx_data, exp_tx);
        check_eq("rx_ready", {7'b0, rx_ready}, {7'b0, rx_q.size() < RXD});
        check_eq("io_in", io_in, exp_rx);
    endtask

    // Predict the effect of the current inputs, cross the edge, then check outputs.
    task automatic step();
        int txn;
        int rxn;
        bit tx_pop;
        bit rd_ok;
        bit und_set;
        bit drop_set;
        txn = tx_q.size();
        rxn = rx_q.size();
        tx_pop = tx_ready && (txn > 0);
        if (tx_pop) begin
            $display("[TB] tx drain %02h", tx_data);
            check_eq("tx_drain", tx_data, tx_q.pop_front());
        end
        drop_set = 1'b0;
        if (io_write) begin
            if (txn < TXD || tx_pop) tx_q.push_back(io_out);
            else drop_set = 1'b1;
            $display("[TB] cpu out %02h", io_out);
        end
        rd_ok   = io_read && (rxn > 0);
        und_set = io_read && (rxn == 0);
        if (rd_ok) begin
            $display("[TB] cpu in %02h", io_in);
            check_eq("rx_read", io_in, rx_q.pop_front());
        end
        if (rx_valid && rxn < RXD) begin
            rx_q.push_back(rx_data);
            $display("[TB] rx accept %02h", rx_data);
        end
        if (rd_ok) begin
            m_drop = 1'b0;
            m_und  = 1'b0;
        end
        if (drop_set) m_drop = 1'b1;
        if (und_set)  m_und  = 1'b1;
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        tx_q.delete();
        rx_q.delete();
        m_drop = 1'b0;
        m_und  = 1'b0;
        check_eq("rst_status", io_status, 8'h04);
        check_eq("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
        check_eq("rst_tx_data", tx_data, 8'h00);
        check_eq("rst_rx_ready", {7'b0, rx_ready}, 8'h01);
        check_eq("rst_io_in", io_in, 8'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all();
    endtask

    initial begin
        reset    = 1'b1;
        io_out   = 8'h00;
        io_write = 1'b0;
        io_read  = 1'b0;
        tx_ready = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // TX basic ordering and first-byte latency
        io_write = 1'b1; io_out = 8'hA1; step();
        check_eq("tx_first", tx_data, 8'hA1);
        io_out = 8'hB2; step();
        io_out = 8'hC3; step();
        io_write = 1'b0;
        check_eq("st_three", io_status, 8'h00);
        tx_ready = 1'b1;
        repeat (4) step();
        check_eq("st_drained", io_status, 8'h04);

        // TX overflow drops the fifth byte
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            io_write = 1'b1;
            io_out   = 8'h10 + 8'(i);
            step();
            if (i == 3) check_eq("tx_full_bit", {7'b0, io_status[1]}, 8'h01);
        end
        io_write = 1'b0;
        check_eq("st_dropped", io_status, 8'h0A);
        tx_ready = 1'b1;
        repeat (5) step();
        tx_ready = 1'b0;
        do_reset();

        // TX full with simultaneous drain and write
        for (int i = 0; i < 4; i++) begin
            io_write = 1'b1;
            io_out   = 8'h20 + 8'(i);
            step();
        end
        tx_ready = 1'b1; io_out = 8'h55; step();
        io_write = 1'b0; tx_ready = 1'b0;
        check_eq("st_full_keep", io_status, 8'h02);
        tx_ready = 1'b1;
        repeat (5) step();
        tx_ready = 1'b0;

        // RX ordering, fill and back-pressure
        rx_valid = 1'b1; rx_data = 8'h3C; step();
        rx_data = 8'h7E; step();
        rx_valid = 1'b0;
        check_eq("rx_head", io_in, 8'h3C);
        check_eq("rx_avail", {7'b0, io_status[0]}, 8'h01);
        io_read = 1'b1; step();
        io_read = 1'b0;
        check_eq("rx_second", io_in, 8'h7E);
        rx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rx_data = 8'h80 + 8'(i);
            step();
        end
        rx_data = 8'h83;
        repeat (3) step();
        check_eq("rx_full_ready", {7'b0, rx_ready}, 8'h00);
        io_read = 1'b1; step();
        io_read = 1'b0; step();
        rx_valid = 1'b0;
        io_read = 1'b1;
        repeat (4) step();
        io_read = 1'b0;
        step();

        // RX underrun and its clearing by a good read
        io_read = 1'b1; step();
        io_read = 1'b0;
        check_eq("underrun_set", {7'b0, io_status[4]}, 8'h01);
        check_eq("underrun_in", io_in, 8'h00);
        rx_valid = 1'b1; rx_data = 8'h01; step();
        rx_valid = 1'b0;
        io_read = 1'b1; step();
        io_read = 1'b0;
        check_eq("underrun_clr", {7'b0, io_status[4]}, 8'h00);

        // Reset in the middle of traffic
        io_write = 1'b1; io_out = 8'hD1; rx_valid = 1'b1; rx_data = 8'hE1; step();
        io_out = 8'hD2; rx_data = 8'hE2; step();
        io_write = 1'b0; rx_data = 8'hE3; step();
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        do_reset();
        tx_ready = 1'b0;
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/neander_io_port.md
Name: neander_io_port

Overview:
- Peripheral-side responder for the NEANDER-X CPU I/O interface.
- On OUT, the CPU drives the accumulator on io_out with a one-cycle io_write strobe. This block buffers those bytes in a TX FIFO and drains them to an external byte sink over a valid/ready handshake.
- In the other direction, it accepts bytes from an external source into an RX FIFO and presents the head byte and a status byte to the CPU. These feed the CPU's IN port 0 (data) and IN port 1 (status).
- Sits between the datapath I/O pins and the chip-level I/O (tinytapeout user pins).

Parameters:
- TX_DEPTH, 4, TX FIFO entries; power of two, minimum 2.
- RX_DEPTH, 4, RX FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- io_out  input  8  byte from CPU accumulator (OUT data).
- io_write  input  1  one-cycle strobe from the control unit on OUT; pushes io_out into the TX FIFO.
- io_read  input  1  one-cycle strobe from the control unit when IN port 0 is consumed; pops the RX FIFO.
- io_in  output  8  RX FIFO head byte; 8'h00 when the RX FIFO is empty.
- io_status  output  8  status byte (bit map under Behaviour).
- tx_data  output  8  TX FIFO head byte to the external sink.
- tx_valid  output  1  TX FIFO non-empty.
- tx_ready  input  1  external sink accepts tx_data this cycle.
- rx_data  input  8  byte from the external source.
- rx_valid  input  1  external source offers rx_data.
- rx_ready  output  1  RX FIFO not full.

Behaviour:
- Clock and reset: clk is the clock; reset is asynchronous and active-high.
- Reset state: both FIFOs empty (pointers and counts 0) and sticky flags cleared. Resulting outputs:
  - tx_valid=0, tx_data=8'h00
  - rx_ready=1, io_in=8'h00
  - io_status=8'h04 (only tx_empty set)
- Reset asserted mid-transfer discards all buffered bytes. No partial state survives.
- io_status bit map:
  - [0] rx_avail = RX count != 0
  - [1] tx_full = TX count == TX_DEPTH
  - [2] tx_empty = TX count == 0
  - [3] tx_dropped: sticky
  - [4] rx_underrun: sticky
  - [7:5] = 0
- Output timing: io_in, io_status, tx_valid, tx_data and rx_ready are combinational from registered FIFO state only. There are no combinational paths from any input to any output.
- TX push: when io_write=1, io_out is written at the rising edge.
  - If the FIFO was empty, tx_valid and tx_data reflect the byte in the next cycle (1-cycle latency).
- TX pop: when tx_valid and tx_ready are both 1, the head is removed at the edge.
- TX full: io_write while full and no pop in the same cycle drops the byte and sets tx_dropped.
  - io_write while full with a simultaneous pop is accepted; count is unchanged.
- TX push and pop together when not full: both occur; count is unchanged.
- RX push: when rx_valid and rx_ready are both 1, rx_data is stored at the edge. io_in and rx_avail update in the next cycle.
  - rx_ready=0 when the RX FIFO is full. The source must hold its byte, so no RX data is ever lost.
- RX pop: io_read=1 while non-empty pops the head at the edge.
  - io_read while empty sets rx_underrun and changes nothing else.
- RX push and pop together when full: not possible, because rx_ready=0.
  - When RX is non-empty and not full, push and pop in the same cycle both occur.
- Sticky flag clearing: tx_dropped and rx_underrun are cleared by any io_read in which the RX FIFO is non-empty (a successful data read).
  - Set and clear in the same cycle: set wins. For example, underrun cannot coincide with a successful read, so this only matters for tx_dropped.
- Pointer arithmetic: pointers are log2(DEPTH) bits and wrap modulo DEPTH. Counts are log2(DEPTH)+1 bits.
- Ordering: strict FIFO order in both directions.

Decomposition:
- Package neander_io_pkg holds:
  - status bit index constants: ST_RX_AVAIL=0, ST_TX_FULL=1, ST_TX_EMPTY=2, ST_TX_DROPPED=3, ST_RX_UNDERRUN=4
  - port address constants: IO_PORT_DATA=8'h00, IO_PORT_STATUS=8'h01
- One sub-module, io_sync_fifo (parameters WIDTH, DEPTH).
  - Ports: push, pop, din, dout, count, full, empty.
  - Instantiated twice, once for TX and once for RX.
  - Overflow and underflow policy lives in the top-level block, not in the FIFO.

Test Plan:
- Reset, then tx_ready=0 and io_write with 8'hA1, 8'hB2, 8'hC3 → tx_valid=1 and tx_data=8'hA1 one cycle after the first write; io_status=8'h00. Raise tx_ready → tx_data sequence A1, B2, C3, then tx_valid=0 and io_status=8'h04.
- tx_ready=0, 5 writes 8'h10–8'h14 → after the 4th, io_status[1]=1. The 5th is dropped, giving io_status=8'h0A. Drain order is 10, 11, 12, 13.
- TX full with tx_ready=1 and io_write=8'h55 in the same cycle → count stays 4, tx_dropped stays 0, and 8'h55 emerges last.
- rx_valid held with 8'h3C then 8'h7E → io_in=8'h3C and io_status[0]=1. After io_read, io_in=8'h7E. Fill 4 entries → rx_ready=0 and the source's 5th byte is held, not lost.
- io_read while RX empty → io_status[4]=1 and io_in=8'h00. Push 8'h01 then io_read → io_status[4] clears.
- Reset asserted mid-drain with 2 TX bytes and 3 RX bytes → next cycle io_status=8'h04, tx_valid=0, rx_ready=1, io_in=8'h00.
